// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract
// step per cycle, with start/busy/done handshake and flush abort.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_div0;
    logic              w_step;
    logic              w_fix;

    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_op;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_result;
    logic [CW-1:0]     r_count;
    logic              r_neg;

    // Operand decode at acceptance: signedness, magnitudes, result sign
    logic              w_is_div;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg_load;

    assign w_is_div   = funct3[2];
    assign w_sgn_a    = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_sgn_b    = w_is_div ? ~funct3[0] : ~funct3[1];
    assign w_a_neg    = w_sgn_a & op_a[XLEN-1];
    assign w_b_neg    = w_sgn_b & op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~op_a + XLEN'(1)) : op_a;
    assign w_b_mag    = w_b_neg ? (~op_b + XLEN'(1)) : op_b;
    // Remainder follows the dividend; product and quotient follow sign(a)^sign(b)
    assign w_neg_load = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // Iteration datapath: hi/lo hold accumulator/multiplier or remainder/quotient
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_trial;
    logic [XLEN:0]     w_diff;
    logic              w_fits;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : {(XLEN+1){1'b0}});
    assign w_trial = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_trial - {1'b0, r_op};
    assign w_fits  = ~w_diff[XLEN];

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg ? (~w_prod + (2*XLEN)'(1)) : w_prod;
    assign w_quo_fix  = r_neg ? (~r_lo + XLEN'(1)) : r_lo;
    assign w_rem_fix  = r_neg ? (~r_hi + XLEN'(1)) : r_hi;

    always_comb begin
        w_fix_res = w_prod_fix[XLEN-1:0];
        if (r_f3[2]) begin
            w_fix_res = r_f3[1] ? w_rem_fix : w_quo_fix;
        end else if (r_f3[1:0] != 2'b00) begin
            w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_div0      = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_load = 1'b1;
                    if (w_is_div && (op_b == '0)) begin
                        w_div0      = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_count == LAST) begin
                        w_state_nxt = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_fix       = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f3     <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
        end else begin
            if (w_load) begin
                r_f3    <= funct3;
                r_op    <= w_is_div ? w_b_mag : w_a_mag;
                r_hi    <= '0;
                r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                r_count <= '0;
                r_neg   <= w_neg_load;
            end
            // Divide by zero bypasses iteration entirely
            if (w_div0) begin
                r_result <= funct3[1] ? op_a : {XLEN{1'b1}};
            end
            if (w_step) begin
                r_count <= r_count + CW'(1);
                if (r_f3[2]) begin
                    r_hi <= w_fits ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_fits};
                end else begin
                    r_hi <= w_sum[XLEN:1];
                    r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                end
            end
            if (w_fix) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer: results, latency, ignored
// starts, flush abort and asynchronous reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request; returns at the falling edge of the cycle after acceptance
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit push);
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    task automatic wait_done(input string tag, input int cyc0, input int exp_lat);
        int cyc;
        logic [31:0] e;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, " result"}, result, e);
    endtask

    logic [2:0]  t_f3  [16];
    logic [31:0] t_a   [16];
    logic [31:0] t_b   [16];
    logic [31:0] t_exp [16];
    int          t_lat [16];
    string       t_name[16];

    task automatic set_vec(input int i, input string n, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e, input int l);
        t_name[i] = n; t_f3[i] = f; t_a[i] = a; t_b[i] = b; t_exp[i] = e; t_lat[i] = l;
    endtask

    initial begin
        int seen;
        rst    = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;

        set_vec(0,  "mulh",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        set_vec(1,  "mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        set_vec(2,  "mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        set_vec(3,  "div",       3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        set_vec(4,  "rem",       3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        set_vec(5,  "divu",      3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34);
        set_vec(6,  "remu",      3'd7, 32'hFFFF_FFF9, 32'd2,         32'd1,         34);
        set_vec(7,  "divu0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        set_vec(8,  "rem0",      3'd6, 32'd5,         32'd0,         32'd5,         1);
        set_vec(9,  "div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        set_vec(10, "rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34);
        set_vec(11, "mul_big",   3'd0, 32'h1234_5678, 32'd9,         32'hA3D7_0A38, 34);
        set_vec(12, "div_negb",  3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        set_vec(13, "rem_negb",  3'd6, 32'd100,       32'hFFFF_FFF9, 32'd2,         34);
        set_vec(14, "remu0",     3'd7, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
        set_vec(15, "div0",      3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);

        #12;
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset result", result,      32'd0);
        @(negedge clk);
        rst = 1'b1;

        // MUL 7 x -3 with handshake timing
        launch(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        check("mul busy c1", 32'(busy), 32'd1);
        check("mul done c1", 32'(done), 32'd0);
        wait_done("mul", 1, 34);
        check("mul busy at done", 32'(busy), 32'd1);
        @(negedge clk);
        check("mul done after", 32'(done), 32'd0);
        check("mul busy after", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            launch(t_f3[i], t_a[i], t_b[i], t_exp[i], 1'b1);
            wait_done(t_name[i], 1, t_lat[i]);
        end

        // Second start mid-operation must be ignored
        launch(3'd0, 32'd3, 32'd5, 32'd15, 1'b1);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd0;
        op_a   = 32'd100;
        op_b   = 32'd100;
        @(negedge clk);
        start  = 1'b0;
        wait_done("busy start", 6, 34);

        // Start coinciding with done must be ignored
        start  = 1'b1;
        funct3 = 3'd0;
        op_a   = 32'd2;
        op_b   = 32'd2;
        @(negedge clk);
        start  = 1'b0;
        check("start at done busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("start at done idle", 32'(busy), 32'd0);
        check("start at done result", result, 32'd15);

        // Flush at cycle 10 aborts without done or result update
        launch(3'd0, 32'd6, 32'd7, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush result", result, 32'd15);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("flush no done", 32'(seen), 32'd0);

        // Asynchronous reset mid-operation at cycle 20
        launch(3'd0, 32'd6, 32'd7, 32'd0, 1'b0);
        repeat (19) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async rst busy",   32'(busy), 32'd0);
        check("async rst done",   32'(done), 32'd0);
        check("async rst result", result,    32'd0);
        @(negedge clk);
        rst = 1'b1;

        launch(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_done("divu after rst", 1, 34);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
